// File: rtl/dmem_pkg.sv
// Shared types for the data-RAM arbiter: dataSize encodings, sequencer
// states, the latched command record and the alignment rule.
package dmem_pkg;

  localparam int DMEM_AW = 8;   // byte address width
  localparam int DMEM_DW = 32;  // four byte lanes

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;  // any 1x encoding is a word

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RD   = 2'd2
  } dmem_state_e;

  // owner: 0 = port A, 1 = port B
  typedef struct packed {
    logic               wren;
    logic [DMEM_AW-1:0] addr;
    logic [DMEM_DW-1:0] data;
    logic               isSigned;
    logic [1:0]         dataSize;
    logic               owner;
  } dmem_cmd_t;

  // Half needs addr[0]==0, word needs addr[1:0]==0; bytes always fit.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] lo);
    return ((size == SZ_HALF) && lo[0]) || (size[1] && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/rr_arb2_r0.sv
// Two-way round-robin arbiter. Grant is combinational while enabled;
// the priority pointer moves only when the caller reports a grant taken.
module rr_arb2_r0 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       upd,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic prio_b;  // 1: B wins a tie, 0: A wins a tie

  // Single requester wins outright; a tie goes to the pointer's side.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = prio_b ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  // After a grant, favour the port that was not served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   prio_b <= 1'b0;
    else if (upd) prio_b <= gnt[0];
  end

endmodule

// File: rtl/dmem_arbiter_r0.sv
// Two-port (CPU A, debug/DMA B) arbiter and sequencer for the byte-lane
// data RAM. A granted command is latched and replayed onto ram_* for one
// EXEC cycle (writes) or EXEC+RD (reads) so the RAM's lane select and
// extension see stable sideband when ram_q comes back.
// Build option: DMEM_ARB_ALIGN_CHK_EN enables misaligned half/word
// detection with an immediate err response and no RAM access; without
// it every command goes to the RAM and a_err/b_err are tied low.
module dmem_arbiter_r0
  import dmem_pkg::*;
#(
  parameter int BIT_WIDTH  = 32,  // must equal DMEM_DW
  parameter int ADDR_WIDTH = 8    // must equal DMEM_AW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  a_wren,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [BIT_WIDTH-1:0]  a_data,
  input  logic                  a_isSigned,
  input  logic [1:0]            a_dataSize,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic                  a_err,
  output logic [BIT_WIDTH-1:0]  a_rdata,
  input  logic                  b_req,
  input  logic                  b_wren,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [BIT_WIDTH-1:0]  b_data,
  input  logic                  b_isSigned,
  input  logic [1:0]            b_dataSize,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic                  b_err,
  output logic [BIT_WIDTH-1:0]  b_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [BIT_WIDTH-1:0]  ram_data,
  output logic                  ram_wren,
  output logic                  ram_isSigned,
  output logic [1:0]            ram_dataSize,
  input  logic [BIT_WIDTH-1:0]  ram_q
);

  localparam int NP = 2;

  dmem_state_e                  state;
  dmem_cmd_t                    cmd;
  dmem_cmd_t                    sel;
  logic [NP-1:0]                req;
  logic [NP-1:0]                gnt;
  logic [NP-1:0]                rvalid;
  logic [NP-1:0][BIT_WIDTH-1:0] rdata;
  logic                         win;
  logic                         mis;
  logic                         idle;

  assign req  = {b_req, a_req};
  assign idle = (state == ST_IDLE);

  rr_arb2_r0 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (idle),
    .upd   (|gnt),
    .req   (req),
    .gnt   (gnt)
  );

  assign a_gnt = gnt[0];
  assign b_gnt = gnt[1];
  assign win   = gnt[1];

  // Select the winning port's command fields.
  always_comb begin
    sel = '0;
    if (win) begin
      sel.wren     = b_wren;
      sel.addr     = b_addr;
      sel.data     = b_data;
      sel.isSigned = b_isSigned;
      sel.dataSize = b_dataSize;
      sel.owner    = 1'b1;
    end else begin
      sel.wren     = a_wren;
      sel.addr     = a_addr;
      sel.data     = a_data;
      sel.isSigned = a_isSigned;
      sel.dataSize = a_dataSize;
      sel.owner    = 1'b0;
    end
  end

`ifdef DMEM_ARB_ALIGN_CHK_EN
  assign mis = is_misaligned(sel.dataSize, sel.addr[1:0]);
`else
  assign mis = 1'b0;
`endif

  // Sequencer: accept in IDLE, drive RAM in EXEC, capture ram_q in RD.
  // A misaligned command never loads cmd, so ram_* keep their old values
  // and the response is turned around directly from IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cmd    <= '0;
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      rvalid <= '0;
      rdata  <= '0;
      unique case (state)
        ST_IDLE: begin
          if (|gnt) begin
            if (mis) begin
              rvalid[win] <= 1'b1;
            end else begin
              cmd   <= sel;
              state <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          if (cmd.wren) begin
            rvalid[cmd.owner] <= 1'b1;
            state             <= ST_IDLE;
          end else begin
            state <= ST_RD;
          end
        end
        ST_RD: begin
          rvalid[cmd.owner] <= 1'b1;
          rdata[cmd.owner]  <= ram_q;
          state             <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DMEM_ARB_ALIGN_CHK_EN
  logic [NP-1:0] err;

  // Error flag rides alongside the IDLE-cycle rvalid for misaligned grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= '0;
    end else begin
      err <= '0;
      if (idle && (|gnt) && mis) err[win] <= 1'b1;
    end
  end

  assign a_err = err[0];
  assign b_err = err[1];
`else
  assign a_err = 1'b0;
  assign b_err = 1'b0;
`endif

  assign a_rvalid = rvalid[0];
  assign b_rvalid = rvalid[1];
  assign a_rdata  = rdata[0];
  assign b_rdata  = rdata[1];

  // Sideband holds cmd through RD; wren is live only in EXEC so an async
  // reset kills an in-flight write immediately.
  assign ram_addr     = cmd.addr;
  assign ram_data     = cmd.data;
  assign ram_isSigned = cmd.isSigned;
  assign ram_dataSize = cmd.dataSize;
  assign ram_wren     = (state == ST_EXEC) && cmd.wren;

endmodule

// File: tb/tb_dmem_arbiter_r0.sv
// Bench for dmem_arbiter_r0: byte-lane RAM model, two requester
// processes, and a cycle-level reference of grants, responses and memory.
module tb_dmem_arbiter_r0;

  localparam int TMO = 100;

  typedef struct {
    logic        wren;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        sgn;
    logic [1:0]  sz;
    int          gap;
  } tcmd_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic  req_v [2];
  tcmd_t cmd_v [2];
  tcmd_t q0[$];
  tcmd_t q1[$];

  logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
  logic [31:0] a_rdata, b_rdata, ram_data, ram_q;
  logic [7:0]  ram_addr;
  logic        ram_wren, ram_isSigned;
  logic [1:0]  ram_dataSize;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter_r0 #(.BIT_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(req_v[0]), .a_wren(cmd_v[0].wren), .a_addr(cmd_v[0].addr),
    .a_data(cmd_v[0].data), .a_isSigned(cmd_v[0].sgn), .a_dataSize(cmd_v[0].sz),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(req_v[1]), .b_wren(cmd_v[1].wren), .b_addr(cmd_v[1].addr),
    .b_data(cmd_v[1].data), .b_isSigned(cmd_v[1].sgn), .b_dataSize(cmd_v[1].sz),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_err(b_err), .b_rdata(b_rdata),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_isSigned(ram_isSigned), .ram_dataSize(ram_dataSize), .ram_q(ram_q)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  // ---- byte-lane RAM: registered word read, lanes/extension on output ----
  logic [7:0]  ram_mem [256] = '{default: 8'h00};
  logic [31:0] ram_word = 32'h0;

  always @(posedge clk) begin
    if (ram_wren) begin
      if (ram_dataSize[1])
        for (int i = 0; i < 4; i++) ram_mem[(int'(ram_addr) & 'hFC) + i] <= ram_data[8*i +: 8];
      else if (ram_dataSize[0])
        for (int i = 0; i < 2; i++) ram_mem[(int'(ram_addr) & 'hFE) + i] <= ram_data[8*i +: 8];
      else
        ram_mem[ram_addr] <= ram_data[7:0];
    end
    ram_word <= {ram_mem[(int'(ram_addr) & 'hFC) + 3], ram_mem[(int'(ram_addr) & 'hFC) + 2],
                 ram_mem[(int'(ram_addr) & 'hFC) + 1], ram_mem[int'(ram_addr) & 'hFC]};
  end

  always_comb begin
    logic [7:0]  lb;
    logic [15:0] lh;
    lb = ram_word[8*ram_addr[1:0] +: 8];
    lh = ram_word[16*ram_addr[1] +: 16];
    if (ram_dataSize[1])      ram_q = ram_word;
    else if (ram_dataSize[0]) ram_q = ram_isSigned ? {{16{lh[15]}}, lh} : {16'h0, lh};
    else                      ram_q = ram_isSigned ? {{24{lb[7]}}, lb} : {24'h0, lb};
  end

  // ---- reference: byte memory, arbitration pointer, expected timeline ----
  logic [7:0] ref_mem [256] = '{default: 8'h00};
  int    ptr, free_cyc, pend_port, pend_cyc, acc_cyc;
  bit    pend_on, pend_err, acc_on, acc_rd;
  logic [31:0] pend_data;
  tcmd_t acc_c;

  function automatic int nbytes(input logic [1:0] sz);
    return sz[1] ? 4 : (sz[0] ? 2 : 1);
  endfunction

  function automatic bit ref_mis(input tcmd_t c);
`ifdef DMEM_ARB_ALIGN_CHK_EN
    return (int'(c.addr) % nbytes(c.sz)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_rd(input tcmd_t c);
    int n, base;
    logic [31:0] v;
    n = nbytes(c.sz);
    base = int'(c.addr) - (int'(c.addr) % n);
    v = 32'h0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[base + i];
    if (c.sgn && n < 4) begin
      if (v[8*n-1]) for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
    end
    return v;
  endfunction

  task automatic ref_wr(input tcmd_t c);
    int n, base;
    n = nbytes(c.sz);
    base = int'(c.addr) - (int'(c.addr) % n);
    for (int i = 0; i < n; i++) ref_mem[base + i] = c.data[8*i +: 8];
  endtask

  always @(negedge clk) begin
    logic [1:0]  eg;
    logic [31:0] rv, rd, er;
    bit hit;
    int w;
    tcmd_t c;
    if (!rst_n) begin
      ptr = 0; free_cyc = 0; pend_on = 0; acc_on = 0;
    end else if (mon_en) begin
      for (int p = 0; p < 2; p++) begin
        hit = pend_on && (pend_cyc == cyc) && (pend_port == p);
        rv = p ? 32'(b_rvalid) : 32'(a_rvalid);
        rd = p ? b_rdata : a_rdata;
        er = p ? 32'(b_err) : 32'(a_err);
        chk(p ? "b_rvalid" : "a_rvalid", rv, 32'(hit));
        chk(p ? "b_rdata" : "a_rdata", rd, hit ? pend_data : 32'h0);
        chk(p ? "b_err" : "a_err", er, 32'(hit && pend_err));
      end
      if (pend_on && pend_cyc == cyc) pend_on = 0;
      chk("ram_wren", 32'(ram_wren), 32'(acc_on && acc_c.wren && cyc == acc_cyc));
      if (acc_on && (cyc == acc_cyc || (acc_rd && cyc == acc_cyc + 1))) begin
        chk("ram_addr", 32'(ram_addr), 32'(acc_c.addr));
        chk("ram_isSigned", 32'(ram_isSigned), 32'(acc_c.sgn));
        chk("ram_dataSize", 32'(ram_dataSize), 32'(acc_c.sz));
        if (acc_c.wren) chk("ram_data", ram_data, acc_c.data);
      end
      if (acc_on && cyc >= acc_cyc + (acc_rd ? 1 : 0)) acc_on = 0;
      eg = 2'b00;
      if (cyc >= free_cyc && (req_v[0] || req_v[1])) begin
        if (req_v[0] && req_v[1]) w = ptr;
        else w = req_v[1] ? 1 : 0;
        ptr = 1 - w;
        eg[w] = 1'b1;
        c = cmd_v[w];
        pend_on = 1; pend_port = w; pend_err = 0; pend_data = 32'h0;
        if (ref_mis(c)) begin
          pend_err = 1; pend_cyc = cyc + 1; free_cyc = cyc + 1;
        end else begin
          acc_on = 1; acc_cyc = cyc + 1; acc_rd = !c.wren; acc_c = c;
          if (c.wren) begin
            ref_wr(c); pend_cyc = cyc + 2; free_cyc = cyc + 2;
          end else begin
            pend_data = ref_rd(c); pend_cyc = cyc + 3; free_cyc = cyc + 3;
          end
        end
      end
      chk("a_gnt", 32'(a_gnt), 32'(eg[0]));
      chk("b_gnt", 32'(b_gnt), 32'(eg[1]));
    end
  end

  // ---- requesters ----
  function automatic logic gnt_of(input int p);
    return p ? b_gnt : a_gnt;
  endfunction

  function automatic tcmd_t mk(input logic w, input logic [7:0] a, input logic [31:0] d,
                               input logic s, input logic [1:0] sz, input int gap);
    tcmd_t c;
    c.wren = w; c.addr = a; c.data = d; c.sgn = s; c.sz = sz; c.gap = gap;
    return c;
  endfunction

  task automatic port_run(input int p);
    tcmd_t c;
    int n;
    bit own;
    own = 0;
    forever begin
      @(posedge clk); #1;
      if ((p == 0 && q0.size() > 0) || (p == 1 && q1.size() > 0)) begin
        if (p == 0) c = q0.pop_front();
        else        c = q1.pop_front();
        if (c.gap > 0) begin
          req_v[p] = 1'b0;
          repeat (c.gap) @(posedge clk);
          #1;
        end
        cmd_v[p] = c;
        req_v[p] = 1'b1;
        own = 1;
        n = 0;
        @(negedge clk);
        while (!gnt_of(p) && n < TMO) begin @(negedge clk); n++; end
        if (!gnt_of(p)) begin
          chk(p ? "b_gnt_timeout" : "a_gnt_timeout", 32'(gnt_of(p)), 32'd1);
          req_v[p] = 1'b0;
        end
      end else if (own) begin
        req_v[p] = 1'b0;
        own = 0;
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || req_v[0] || req_v[1] || pend_on || cyc < free_cyc)
           && n < 5000) begin
      @(negedge clk); n++;
    end
    if (n >= 5000) chk("idle_timeout", 32'(pend_on), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_chk(input string pfx);
    chk({pfx, "a_gnt"}, 32'(a_gnt), 0);       chk({pfx, "b_gnt"}, 32'(b_gnt), 0);
    chk({pfx, "a_rvalid"}, 32'(a_rvalid), 0); chk({pfx, "b_rvalid"}, 32'(b_rvalid), 0);
    chk({pfx, "a_err"}, 32'(a_err), 0);       chk({pfx, "b_err"}, 32'(b_err), 0);
    chk({pfx, "a_rdata"}, a_rdata, 0);        chk({pfx, "b_rdata"}, b_rdata, 0);
    chk({pfx, "ram_addr"}, 32'(ram_addr), 0); chk({pfx, "ram_data"}, ram_data, 0);
    chk({pfx, "ram_wren"}, 32'(ram_wren), 0); chk({pfx, "ram_isSigned"}, 32'(ram_isSigned), 0);
    chk({pfx, "ram_dataSize"}, 32'(ram_dataSize), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tcmd_t c;
    req_v[0] = 1'b0; req_v[1] = 1'b0;
    cmd_v[0] = mk(0, 0, 0, 0, 0, 0); cmd_v[1] = mk(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    reset_chk("rst_");
    rst_n = 1'b1;
    #1 mon_en = 1'b1;
    fork
      port_run(0);
      port_run(1);
    join_none

    // A: word write then word read; signed byte read of the top lane
    q0.push_back(mk(1, 8'h10, 32'hDEADBEEF, 0, 2'b10, 0));
    q0.push_back(mk(0, 8'h10, 32'h0, 0, 2'b10, 0));
    q0.push_back(mk(0, 8'h13, 32'h0, 1, 2'b00, 0));
    wait_idle();
    // B once so the pointer favours A, then three back-to-back contests
    q1.push_back(mk(0, 8'h12, 32'h0, 1, 2'b01, 0));
    wait_idle();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(mk(0, 8'(8'h10 + i), 32'h0, 1, 2'b00, 0));
      q1.push_back(mk(0, 8'(8'h11 + i), 32'h0, 0, 2'b00, 0));
    end
    wait_idle();
    // B half write at an odd address, then check the word it would touch
    q1.push_back(mk(1, 8'h11, 32'h0000CAFE, 0, 2'b01, 0));
    wait_idle();
    q0.push_back(mk(0, 8'h10, 32'h0, 0, 2'b10, 0));
    wait_idle();

    // Reset during EXEC of a write: wren must drop at once, nothing follows
    mon_en = 1'b0;
    @(posedge clk); #2;
    cmd_v[0] = mk(1, 8'h20, 32'h12345678, 0, 2'b10, 0);
    req_v[0] = 1'b1;
    @(negedge clk); chk("midrst_a_gnt", 32'(a_gnt), 1);
    @(posedge clk); #2 req_v[0] = 1'b0;
    @(negedge clk); chk("midrst_exec_wren", 32'(ram_wren), 1);
    #1 rst_n = 1'b0;
    #1 reset_chk("midrst_");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 mon_en = 1'b1;
    q0.push_back(mk(0, 8'h20, 32'h0, 0, 2'b10, 0));
    q1.push_back(mk(0, 8'h20, 32'h0, 0, 2'b10, 0));
    wait_idle();

    // A writes, B reads the same word in the next grant
    q0.push_back(mk(1, 8'h24, 32'hA5A55A5A, 0, 2'b10, 0));
    q1.push_back(mk(0, 8'h24, 32'h0, 0, 2'b10, 0));
    wait_idle();

    // Randomized traffic on both ports
    for (int i = 0; i < 300; i++) begin
      c = mk(1'($urandom % 2), 8'($urandom % 64), $urandom, 1'($urandom % 2),
             2'($urandom % 4), int'($urandom % 3));
      if ($urandom % 2) q1.push_back(c);
      else              q0.push_back(c);
    end
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
